// File: rtl/ctx_swap_engine.sv
// Context save/restore engine: streams registers FIRST_REG..LAST_REG between bank and memory.
// Optional CTX_SWAP_SKIP_MASK_EN adds Skip_Mask to leave selected registers untouched.
module ctx_swap_engine #(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 63,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic        Slow_Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Op,
    input  logic [31:0] Base_Addr,
`ifdef CTX_SWAP_SKIP_MASK_EN
    input  logic [63:0] Skip_Mask,
`endif
    output logic        Busy,
    output logic        Done,
    output logic [5:0]  Rb_Reg,
    output logic        Rb_Write,
    output logic [31:0] Rb_Write_Data,
    input  logic [31:0] Rb_Read_Data,
    output logic [31:0] Mem_Addr,
    output logic        Mem_Write,
    output logic        Mem_Read,
    output logic [31:0] Mem_Write_Data,
    input  logic [31:0] Mem_Read_Data,
    input  logic        Mem_Ready
);

    localparam logic [5:0]  FIRST_IDX = 6'(FIRST_REG);
    localparam logic [5:0]  LAST_IDX  = 6'(LAST_REG);
    localparam logic [31:0] STEP      = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_RD,
        S_SAVE_WR,
        S_RST_RD,
        S_RST_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic        op_q, op_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rb_wdata_q, rb_wdata_d;
    logic        skip;
    logic        last;
    state_t      rd_state;

`ifdef CTX_SWAP_SKIP_MASK_EN
    logic [63:0] skip_q, skip_d;
    assign skip = skip_q[idx_q];
`else
    assign skip = 1'b0;
`endif

    assign last     = (idx_q == LAST_IDX);
    assign rd_state = op_q ? S_RST_RD : S_SAVE_RD;

    always_ff @(posedge Slow_Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            mem_wdata_q <= '0;
            rb_wdata_q  <= '0;
`ifdef CTX_SWAP_SKIP_MASK_EN
            skip_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            mem_wdata_q <= mem_wdata_d;
            rb_wdata_q  <= rb_wdata_d;
`ifdef CTX_SWAP_SKIP_MASK_EN
            skip_q      <= skip_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        op_d        = op_q;
        mem_wdata_d = mem_wdata_q;
        rb_wdata_d  = rb_wdata_q;
`ifdef CTX_SWAP_SKIP_MASK_EN
        skip_d      = skip_q;
`endif
        Busy      = 1'b1;
        Done      = 1'b0;
        Rb_Reg    = idx_q;
        Rb_Write  = 1'b0;
        Mem_Addr  = '0;
        Mem_Write = 1'b0;
        Mem_Read  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                Busy   = 1'b0;
                Rb_Reg = '0;
                if (Start) begin
                    idx_d   = FIRST_IDX;
                    addr_d  = Base_Addr;
                    op_d    = Op;
`ifdef CTX_SWAP_SKIP_MASK_EN
                    skip_d  = Skip_Mask;
`endif
                    state_d = Op ? S_RST_RD : S_SAVE_RD;
                end
            end
            S_SAVE_RD: begin
                // a skipped slot still consumes its index and address
                if (skip) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        addr_d = addr_q + STEP;
                    end
                end else begin
                    mem_wdata_d = Rb_Read_Data;
                    state_d     = S_SAVE_WR;
                end
            end
            S_SAVE_WR: begin
                Mem_Write = 1'b1;
                Mem_Addr  = addr_q;
                if (Mem_Ready) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        addr_d  = addr_q + STEP;
                        state_d = rd_state;
                    end
                end
            end
            S_RST_RD: begin
                if (skip) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        addr_d = addr_q + STEP;
                    end
                end else begin
                    Mem_Read = 1'b1;
                    Mem_Addr = addr_q;
                    if (Mem_Ready) begin
                        rb_wdata_d = Mem_Read_Data;
                        state_d    = S_RST_WR;
                    end
                end
            end
            S_RST_WR: begin
                Rb_Write = 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    addr_d  = addr_q + STEP;
                    state_d = rd_state;
                end
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Mem_Write_Data = mem_wdata_q;
    assign Rb_Write_Data  = rb_wdata_q;

endmodule

// File: tb/tb_ctx_swap_engine.sv
// Directed bench for ctx_swap_engine: default instance plus a 61..63 / step-4 instance.
// Skip-mask scenario runs only when CTX_SWAP_SKIP_MASK_EN is defined.
module tb_ctx_swap_engine;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Op = 1'b0;
    logic [31:0] Base_Addr = '0;
    logic [63:0] Skip_Mask = '0;
    logic        Busy, Done, Rb_Write, Mem_Write, Mem_Read;
    logic [5:0]  Rb_Reg;
    logic [31:0] Rb_Write_Data, Rb_Read_Data, Mem_Addr;
    logic [31:0] Mem_Write_Data, Mem_Read_Data;
    logic        Mem_Ready = 1'b0;

    logic        Start2 = 1'b0;
    logic        Busy2, Done2, Rb_Write2, Mem_Write2, Mem_Read2;
    logic [5:0]  Rb_Reg2;
    logic [31:0] Rb_Write_Data2, Rb_Read_Data2, Mem_Addr2, Mem_Write_Data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // bank holds k*3 in register k; memory word at 0x200+k-1 holds 0xA000+k
    assign Rb_Read_Data  = 32'(Rb_Reg) * 32'd3;
    assign Rb_Read_Data2 = 32'(Rb_Reg2) * 32'd3;
    assign Mem_Read_Data = 32'hA000 + (Mem_Addr - 32'h200) + 32'd1;

    ctx_swap_engine u_dut (
        .Slow_Clock    (clk),
        .Reset         (Reset),
        .Start         (Start),
        .Op            (Op),
        .Base_Addr     (Base_Addr),
`ifdef CTX_SWAP_SKIP_MASK_EN
        .Skip_Mask     (Skip_Mask),
`endif
        .Busy          (Busy),
        .Done          (Done),
        .Rb_Reg        (Rb_Reg),
        .Rb_Write      (Rb_Write),
        .Rb_Write_Data (Rb_Write_Data),
        .Rb_Read_Data  (Rb_Read_Data),
        .Mem_Addr      (Mem_Addr),
        .Mem_Write     (Mem_Write),
        .Mem_Read      (Mem_Read),
        .Mem_Write_Data(Mem_Write_Data),
        .Mem_Read_Data (Mem_Read_Data),
        .Mem_Ready     (Mem_Ready)
    );

    ctx_swap_engine #(.FIRST_REG(61), .LAST_REG(63), .ADDR_STEP(4)) u_dut2 (
        .Slow_Clock    (clk),
        .Reset         (Reset),
        .Start         (Start2),
        .Op            (1'b0),
        .Base_Addr     (Base_Addr),
`ifdef CTX_SWAP_SKIP_MASK_EN
        .Skip_Mask     (64'd0),
`endif
        .Busy          (Busy2),
        .Done          (Done2),
        .Rb_Reg        (Rb_Reg2),
        .Rb_Write      (Rb_Write2),
        .Rb_Write_Data (Rb_Write_Data2),
        .Rb_Read_Data  (Rb_Read_Data2),
        .Mem_Addr      (Mem_Addr2),
        .Mem_Write     (Mem_Write2),
        .Mem_Read      (Mem_Read2),
        .Mem_Write_Data(Mem_Write_Data2),
        .Mem_Read_Data (32'd0),
        .Mem_Ready     (1'b1)
    );

    int edge_n = 0;
    int s_edge = 0;
    bit clr_req = 1'b0;
    bit rdy_mode = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    logic [31:0] wa[$], wd[$], rd[$], wa2[$], wd2[$];
    int rr[$];
    int wcnt = 0, cyc = 0;
    int done_cnt = 0, done_cyc = 0, done_wide = 0, done2_cyc = 0;
    int both_err = 0, zero_err = 0, rbw_wide = 0, hold_err = 0, rd_cycles = 0;
    bit prev_done = 0, prev_rbw = 0, pend = 0, p_rd = 0;
    logic [31:0] p_addr = '0, p_data = '0;

    // memory ready model and observation, both at the falling edge
    always @(negedge clk) begin
        if (!rdy_mode) begin
            Mem_Ready = 1'b1;
        end else if (Mem_Read || Mem_Write) begin
            if (wcnt == 2) begin
                Mem_Ready = 1'b1;
                wcnt = 0;
            end else begin
                Mem_Ready = 1'b0;
                wcnt++;
            end
        end else begin
            Mem_Ready = 1'b0;
            wcnt = 0;
        end
        if (clr_req) begin
            wa.delete(); wd.delete(); rd.delete(); rr.delete();
            wa2.delete(); wd2.delete();
            done_cnt = 0; done_cyc = 0; done_wide = 0; done2_cyc = 0;
            both_err = 0; zero_err = 0; rbw_wide = 0; hold_err = 0;
            rd_cycles = 0; prev_done = 0; prev_rbw = 0; pend = 0;
        end
        cyc = edge_n - s_edge;
        if (Mem_Write && Mem_Read) both_err++;
        if (Rb_Write && Rb_Reg == 6'd0) zero_err++;
        if (Rb_Write && prev_rbw) rbw_wide++;
        if (Done) begin
            done_cnt++;
            done_cyc = cyc;
            if (prev_done) done_wide++;
        end
        if (Mem_Read) rd_cycles++;
        if ((Mem_Read || Mem_Write) && pend &&
            (Mem_Addr != p_addr || Mem_Write_Data != p_data || Mem_Read != p_rd))
            hold_err++;
        pend   = (Mem_Read || Mem_Write) && !Mem_Ready;
        p_addr = Mem_Addr;
        p_data = Mem_Write_Data;
        p_rd   = Mem_Read;
        if (Mem_Write && Mem_Ready) begin
            wa.push_back(Mem_Addr);
            wd.push_back(Mem_Write_Data);
        end
        if (Rb_Write) begin
            rr.push_back(int'(Rb_Reg));
            rd.push_back(Rb_Write_Data);
        end
        if (Mem_Write2) begin
            wa2.push_back(Mem_Addr2);
            wd2.push_back(Mem_Write_Data2);
        end
        if (Done2) done2_cyc = cyc;
        prev_done = Done;
        prev_rbw  = Rb_Write;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input bit two, input bit op, input logic [31:0] base);
        Start     = !two;
        Start2    = two;
        Op        = op;
        Base_Addr = base;
        clr_req   = 1'b1;
        s_edge    = edge_n;
        tick();
        Start   = 1'b0;
        Start2  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit two);
        int n = 0;
        while ((two ? Busy2 : Busy) && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 2000), 64'd1);
    endtask

    initial begin
        int bad;
        int n;
        repeat (3) tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_req", 64'({Mem_Write, Mem_Read, Rb_Write}), 64'd0);
        chk("rst_rbreg", 64'(Rb_Reg), 64'd0);
        chk("rst_addr", 64'(Mem_Addr), 64'd0);
        chk("rst_wdata", 64'({Rb_Write_Data, Mem_Write_Data}), 64'd0);
        Reset = 1'b0;
        tick();

        // full save, ready always high
        rdy_mode = 1'b0;
        do_start(1'b0, 1'b0, 32'h100);
        wait_idle("save_timeout", 1'b0);
        chk("save_cnt", 64'(wa.size()), 64'd63);
        bad = 0;
        foreach (wa[i]) begin
            if (wa[i] != 32'h100 + 32'(i) || wd[i] != 32'((i + 1) * 3)) bad++;
        end
        chk("save_seq", 64'(bad), 64'd0);
        if (wa.size() == 63) begin
            chk("save_last_addr", 64'(wa[62]), 64'h13E);
            chk("save_last_data", 64'(wd[62]), 64'd189);
        end
        chk("save_done_cnt", 64'(done_cnt), 64'd1);
        chk("save_done_cyc", 64'(done_cyc), 64'd127);
        chk("save_done_wide", 64'(done_wide), 64'd0);
        chk("save_no_rbw", 64'(rr.size()), 64'd0);

        // full restore, two wait cycles per read
        rdy_mode = 1'b1;
        do_start(1'b0, 1'b1, 32'h200);
        wait_idle("rst_timeout", 1'b0);
        chk("rst_cnt", 64'(rr.size()), 64'd63);
        bad = 0;
        foreach (rr[i]) begin
            if (rr[i] != i + 1 || rd[i] != 32'hA000 + 32'(i + 1)) bad++;
        end
        chk("rst_seq", 64'(bad), 64'd0);
        chk("rst_rd_cycles", 64'(rd_cycles), 64'd189);
        chk("rst_hold", 64'(hold_err), 64'd0);
        chk("rst_reg0", 64'(zero_err), 64'd0);
        chk("rst_rbw_wide", 64'(rbw_wide), 64'd0);
        chk("rst_both", 64'(both_err), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd1);
        chk("rst_no_memw", 64'(wa.size()), 64'd0);

        // Start re-pulse mid-save and during DONE
        rdy_mode = 1'b0;
        do_start(1'b0, 1'b0, 32'h300);
        repeat (5) tick();
        Start = 1'b1; Op = 1'b1; Base_Addr = 32'h999;
        tick();
        Start = 1'b0; Op = 1'b0;
        n = 0;
        while (!Done && n < 500) begin
            tick();
            n++;
        end
        chk("rep_done_seen", 64'(n < 500), 64'd1);
        Start = 1'b1; Base_Addr = 32'h777;
        tick();
        Start = 1'b0;
        chk("rep_idle_after_done", 64'(Busy), 64'd0);
        tick();
        chk("rep_still_idle", 64'(Busy), 64'd0);
        chk("rep_cnt", 64'(wa.size()), 64'd63);
        bad = 0;
        foreach (wa[i]) if (wa[i] != 32'h300 + 32'(i)) bad++;
        chk("rep_addr_seq", 64'(bad), 64'd0);
        chk("rep_done_cnt", 64'(done_cnt), 64'd1);
        chk("rep_no_rbw", 64'(rr.size()), 64'd0);

        // reset after the 10th save write
        do_start(1'b0, 1'b0, 32'h400);
        n = 0;
        while (wa.size() < 10 && n < 500) begin
            tick();
            n++;
        end
        chk("rst10_reach", 64'(n < 500), 64'd1);
        Reset = 1'b1;
        tick();
        chk("rst10_busy", 64'(Busy), 64'd0);
        chk("rst10_req", 64'({Mem_Write, Mem_Read, Rb_Write}), 64'd0);
        chk("rst10_out", 64'({Rb_Reg, Mem_Addr, Mem_Write_Data}), 64'd0);
        Reset = 1'b0;
        tick();
        do_start(1'b0, 1'b0, 32'h500);
        wait_idle("rst10_timeout", 1'b0);
        chk("rst10_cnt", 64'(wa.size()), 64'd63);
        if (wa.size() > 0) begin
            chk("rst10_first_addr", 64'(wa[0]), 64'h500);
            chk("rst10_first_data", 64'(wd[0]), 64'd3);
        end

        // narrow range with address wrap
        do_start(1'b1, 1'b0, 32'hFFFF_FFF8);
        wait_idle("wrap_timeout", 1'b1);
        chk("wrap_cnt", 64'(wa2.size()), 64'd3);
        if (wa2.size() == 3) begin
            chk("wrap_a0", 64'(wa2[0]), 64'hFFFF_FFF8);
            chk("wrap_a1", 64'(wa2[1]), 64'hFFFF_FFFC);
            chk("wrap_a2", 64'(wa2[2]), 64'h0);
            chk("wrap_d", 64'({wd2[0], wd2[2]}), {32'd183, 32'd189});
        end
        chk("wrap_done_cyc", 64'(done2_cyc), 64'd7);

`ifdef CTX_SWAP_SKIP_MASK_EN
        Skip_Mask = (64'd1 << 2) | (64'd1 << 63);
        do_start(1'b0, 1'b0, 32'h600);
        wait_idle("skip_timeout", 1'b0);
        chk("skip_cnt", 64'(wa.size()), 64'd61);
        if (wa.size() == 61) begin
            chk("skip_r3_addr", 64'(wa[1]), 64'h602);
            chk("skip_r3_data", 64'(wd[1]), 64'd9);
            chk("skip_last_addr", 64'(wa[60]), 64'h63D);
            chk("skip_last_data", 64'(wd[60]), 64'd186);
        end
        chk("skip_done_cyc", 64'(done_cyc), 64'd125);
        Skip_Mask = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
